// File: rtl/icache_resp_pkg.sv
// Shared definitions for the icache responder: request op encodings, bus read
// types, geometry constants and the responder FSM state encoding.
package icache_resp_pkg;

  typedef enum logic [2:0] {
    IC_NOP     = 3'd0,
    IC_R       = 3'd1,
    IC_IDX_INV = 3'd2,
    IC_HIT_INV = 3'd3
  } icache_op_t;

  localparam logic [2:0] RD_TYPE_LINE = 3'b100;
  localparam logic [2:0] RD_TYPE_WORD = 3'b010;

  localparam int ICACHE_SETS       = 256;
  localparam int ICACHE_LINE_WORDS = 4;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MISS_REQ,
    ST_REFILL,
    ST_RESP
  } icache_state_t;

endpackage

// File: rtl/icache_way.sv
// One icache way: valid bits (async-cleared), tag and data arrays with a
// synchronous read port, a whole-line write port and a single-set invalidate.
module icache_way #(
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rd_en,
  input  logic [$clog2(SETS)-1:0]    rd_set,
  output logic                       rd_valid,
  output logic [19:0]                rd_tag,
  output logic [LINE_WORDS*32-1:0]   rd_line,
  input  logic                       wr_en,
  input  logic [$clog2(SETS)-1:0]    wr_set,
  input  logic [19:0]                wr_tag,
  input  logic [LINE_WORDS*32-1:0]   wr_line,
  input  logic                       inv_en,
  input  logic [$clog2(SETS)-1:0]    inv_set
);

  logic [SETS-1:0]             valid_q;
  logic [19:0]                 tag_mem  [SETS];
  logic [LINE_WORDS*32-1:0]    data_mem [SETS];

  // An invalidate landing on the set being read this cycle must not be missed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en)  valid_q[wr_set]  <= 1'b1;
      if (inv_en) valid_q[inv_set] <= 1'b0;
      if (rd_en)  rd_valid <= valid_q[rd_set] & ~(inv_en && (inv_set == rd_set));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_set]  <= wr_tag;
      data_mem[wr_set] <= wr_line;
    end
    if (rd_en) begin
      rd_tag  <= tag_mem[rd_set];
      rd_line <= data_mem[rd_set];
    end
  end

endmodule

// File: rtl/icache_resp.sv
// 2-way VIPT instruction-cache responder with burst refill and uncached fetch.
// Define ICACHE_CACOP_EN to accept the IC_IDX_INV / IC_HIT_INV maintenance ops.
module icache_resp
  import icache_resp_pkg::*;
#(
  parameter int SETS          = ICACHE_SETS,
  parameter int LINE_WORDS    = ICACHE_LINE_WORDS,
  parameter int RST_PC_CACHED = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] icache_idx,
  input  logic [2:0]  icache_op,
  input  logic [31:0] icache_pa,
  input  logic        icache_is_cached,
  output logic        icache_busy,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        rd_req,
  output logic [2:0]  rd_type,
  output logic [31:0] rd_addr,
  input  logic        rd_ready,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data
);

  localparam int LW = LINE_WORDS * 32;

  icache_state_t state, state_next;

  logic        s_valid;
  logic [11:2] s_idx;
  logic [31:0] s_pa;
  logic        s_cached;
  logic [7:0]  s_set;

  logic          lookup_ld, req_ok, is_read_s;
  logic          hit, hit_way, hit_resp, miss_start, victim, fill_en;
  logic [1:0]    way_valid, way_hit, inv_way;
  logic [19:0]   way_tag  [2];
  logic [LW-1:0] way_line [2];
  logic [LW-1:0] hit_line, fill_line;

  logic [31:0]     buf_q [LINE_WORDS];
  logic [1:0]      cnt_q;
  logic            flush_seen;
  logic [SETS-1:0] lru_q;

  logic unused_ok;
  assign unused_ok = ^{icache_idx[1:0], 1'(RST_PC_CACHED)};

  assign s_set = s_idx[11:4];

`ifdef ICACHE_CACOP_EN
  logic [2:0] s_op;
  logic       cacop_act;
  assign req_ok    = (icache_op == IC_R) || (icache_op == IC_IDX_INV) || (icache_op == IC_HIT_INV);
  assign is_read_s = (s_op == IC_R);
  assign cacop_act = (state == ST_RUN) && s_valid && !flush_i;
  assign inv_way[0] = cacop_act && (((s_op == IC_IDX_INV) && !s_pa[0]) ||
                                    ((s_op == IC_HIT_INV) && way_hit[0]));
  assign inv_way[1] = cacop_act && (((s_op == IC_IDX_INV) && s_pa[0]) ||
                                    ((s_op == IC_HIT_INV) && way_hit[1]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         s_op <= IC_NOP;
    else if (lookup_ld) s_op <= icache_op;
  end
`else
  assign req_ok    = (icache_op == IC_R);
  assign is_read_s = 1'b1;
  assign inv_way   = 2'b00;
`endif

  for (genvar w = 0; w < 2; w++) begin : g_way
    icache_way #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) u_way (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (lookup_ld),
      .rd_set   (icache_idx[11:4]),
      .rd_valid (way_valid[w]),
      .rd_tag   (way_tag[w]),
      .rd_line  (way_line[w]),
      .wr_en    (fill_en && (victim == 1'(w))),
      .wr_set   (s_set),
      .wr_tag   (s_pa[31:12]),
      .wr_line  (fill_line),
      .inv_en   (inv_way[w]),
      .inv_set  (s_set)
    );
    assign way_hit[w] = way_valid[w] && (way_tag[w] == s_pa[31:12]);
  end

  assign hit      = |way_hit;
  assign hit_way  = way_hit[1];
  assign hit_line = hit_way ? way_line[1] : way_line[0];
  assign victim   = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[s_set]);

  assign hit_resp   = (state == ST_RUN) && s_valid && is_read_s && s_cached && hit && !flush_i;
  assign miss_start = (state == ST_RUN) && s_valid && is_read_s && !flush_i && (!s_cached || !hit);
  assign icache_busy = miss_start || (state == ST_MISS_REQ) || (state == ST_REFILL);
  assign lookup_ld   = !icache_busy && !stall_i;

  // Arrays are written on the final beat so a request captured in RESP sees the new line.
  assign fill_en = (state == ST_REFILL) && ret_valid && ret_last && s_cached;

  always_comb begin
    fill_line = '0;
    for (int k = 0; k < LINE_WORDS; k++) fill_line[k*32 +: 32] = buf_q[k];
    fill_line[{cnt_q, 5'b0} +: 32] = ret_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    rd_req      = 1'b0;
    rd_type     = 3'b000;
    rd_addr     = 32'h0;
    rdata       = 32'h0;
    rdata_valid = 1'b0;
    case (state)
      ST_RUN: begin
        if (miss_start) state_next = ST_MISS_REQ;
        if (hit_resp) begin
          rdata       = hit_line[{s_idx[3:2], 5'b0} +: 32];
          rdata_valid = 1'b1;
        end
      end
      ST_MISS_REQ: begin
        rd_req  = 1'b1;
        rd_type = s_cached ? RD_TYPE_LINE : RD_TYPE_WORD;
        rd_addr = s_cached ? {s_pa[31:4], 4'b0} : s_pa;
        if (rd_ready) state_next = ST_REFILL;
      end
      ST_REFILL: begin
        if (ret_valid && ret_last) state_next = ST_RESP;
      end
      ST_RESP: begin
        rdata       = buf_q[s_cached ? s_pa[3:2] : 2'd0];
        rdata_valid = !flush_seen && !flush_i;
        if (!stall_i) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid  <= 1'b0;
      s_idx    <= '0;
      s_pa     <= '0;
      s_cached <= 1'b0;
    end else if (lookup_ld) begin
      s_valid  <= req_ok && !flush_i;
      s_idx    <= icache_idx[11:2];
      s_pa     <= icache_pa;
      s_cached <= icache_is_cached;
    end else if (flush_i && !icache_busy) begin
      s_valid  <= 1'b0;
    end
  end

  // A flush during the bus transaction is remembered until the response slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 2'd0;
      flush_seen <= 1'b0;
      lru_q      <= '0;
    end else begin
      if (state == ST_MISS_REQ) cnt_q <= 2'd0;
      else if ((state == ST_REFILL) && ret_valid) cnt_q <= cnt_q + 2'd1;

      if (state == ST_RUN) flush_seen <= 1'b0;
      else if (((state == ST_MISS_REQ) || (state == ST_REFILL)) && flush_i) flush_seen <= 1'b1;

      if (fill_en) lru_q[s_set] <= ~victim;
      else if (hit_resp && !stall_i) lru_q[s_set] <= ~hit_way;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == ST_REFILL) && ret_valid) buf_q[cnt_q] <= ret_data;
  end

endmodule
